uart_tx_fifo: RTL and testbench

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_tx_fifo.sv | 119 +++++++++++
 tb/tb_uart_tx_fifo.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// Byte FIFO between the UART transmitter stage and the downstream serializer.
// Single clock (baud_clk), synchronous active-high reset, registered read data.
// Optional sticky overflow/underflow flags with clr_err are compiled in when
// UART_TX_FIFO_ERR_EN is defined; without it the FIFO behaves identically.
module uart_tx_fifo #(
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned ADDR_W   = 4,
  parameter int unsigned AF_LEVEL = 14
) (
  input  logic              baud_clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [7:0]        wr_data,
  input  logic              rd_en,
  output logic [7:0]        rd_data,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic [ADDR_W:0]   count
`ifdef UART_TX_FIFO_ERR_EN
  ,
  input  logic              clr_err,
  output logic              overflow,
  output logic              underflow
`endif
);

  localparam logic [ADDR_W:0] DepthCnt = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] AfCnt    = (ADDR_W + 1)'(AF_LEVEL);

  logic [7:0]        mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [7:0]        rd_data_q, rd_data_d;
  logic              wr_acc, rd_acc;

  // Status flags depend on occupancy alone.
  always_comb begin
    full        = (count_q == DepthCnt);
    empty       = (count_q == '0);
    almost_full = (count_q >= AfCnt);
    count       = count_q;
    rd_data     = rd_data_q;
  end

  // Accept decisions and next-state for pointers, occupancy and read data.
  always_comb begin
    wr_acc    = wr_en && !full;
    rd_acc    = rd_en && !empty;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    rd_data_d = rd_data_q;
    // Pointers wrap naturally since DEPTH == 2**ADDR_W.
    if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_acc) begin
      rd_ptr_d  = rd_ptr_q + 1'b1;
      rd_data_d = mem_q[rd_ptr_q];
    end
    unique case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Control state register; reset discards contents by clearing pointers.
  always_ff @(posedge baud_clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      rd_data_q <= 8'h00;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      rd_data_q <= rd_data_d;
    end
  end

  // Storage array; left uncleared on reset.
  always_ff @(posedge baud_clk) begin
    if (!rst && wr_acc) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

`ifdef UART_TX_FIFO_ERR_EN
  logic overflow_q, underflow_q;

  // Sticky error flags; a new error event beats a simultaneous clear.
  always_ff @(posedge baud_clk) begin
    if (rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (wr_en && full) begin
        overflow_q <= 1'b1;
      end else if (clr_err) begin
        overflow_q <= 1'b0;
      end
      if (rd_en && empty) begin
        underflow_q <= 1'b1;
      end else if (clr_err) begin
        underflow_q <= 1'b0;
      end
    end
  end

  // Expose the flag registers.
  always_comb begin
    overflow  = overflow_q;
    underflow = underflow_q;
  end
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: the driver models accepts and queues the
// expected read bytes; a monitor pops and compares after every rising edge.
module tb_uart_tx_fifo;

  localparam int DEPTH    = 16;
  localparam int ADDR_W   = 4;
  localparam int AF_LEVEL = 14;

  logic            baud_clk = 1'b0;
  logic            rst = 1'b0;
  logic            wr_en = 1'b0;
  logic [7:0]      wr_data = 8'h00;
  logic            rd_en = 1'b0;
  logic [7:0]      rd_data;
  logic            full, empty, almost_full;
  logic [ADDR_W:0] count;
`ifdef UART_TX_FIFO_ERR_EN
  logic            clr_err = 1'b0;
  logic            overflow, underflow;
  logic            exp_ovf = 1'b0;
  logic            exp_udf = 1'b0;
`endif

  uart_tx_fifo #(
    .DEPTH    (DEPTH),
    .ADDR_W   (ADDR_W),
    .AF_LEVEL (AF_LEVEL)
  ) dut (
    .baud_clk    (baud_clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .rd_en       (rd_en),
    .rd_data     (rd_data),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full),
    .count       (count)
`ifdef UART_TX_FIFO_ERR_EN
    ,
    .clr_err     (clr_err),
    .overflow    (overflow),
    .underflow   (underflow)
`endif
  );

  always #5 baud_clk = ~baud_clk;

  logic [7:0] model_q [$];
  logic [7:0] exp_q [$];
  int         checks = 0;
  int         errors = 0;
  bit         checking = 1'b0;
  bit         rd_acc_pend = 1'b0;
  bit         rst_pend = 1'b0;
  int         exp_cnt = 0;
  logic [7:0] exp_rd = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle of stimulus; the model decides acceptance from pre-edge state.
  task automatic step(input logic w, input logic [7:0] d, input logic r, input logic c = 1'b0);
    int  sz;
    bit  ra, wa;
    @(negedge baud_clk);
    rst     = 1'b0;
    wr_en   = w;
    wr_data = d;
    rd_en   = r;
    sz = model_q.size();
    ra = r && (sz != 0);
    wa = w && (sz != DEPTH);
`ifdef UART_TX_FIFO_ERR_EN
    clr_err = c;
    if (w && sz == DEPTH) exp_ovf = 1'b1;
    else if (c)           exp_ovf = 1'b0;
    if (r && sz == 0)     exp_udf = 1'b1;
    else if (c)           exp_udf = 1'b0;
`else
    if (c) begin end
`endif
    if (ra) exp_q.push_back(model_q.pop_front());
    if (wa) model_q.push_back(d);
    rd_acc_pend = ra;
    rst_pend    = 1'b0;
    exp_cnt     = model_q.size();
  endtask

  // Reset cycle, optionally with competing requests to prove rst priority.
  task automatic do_reset(input logic w, input logic r);
    @(negedge baud_clk);
    rst     = 1'b1;
    wr_en   = w;
    wr_data = 8'hEE;
    rd_en   = r;
`ifdef UART_TX_FIFO_ERR_EN
    clr_err = 1'b1;
    exp_ovf = 1'b0;
    exp_udf = 1'b0;
`endif
    model_q.delete();
    exp_q.delete();
    rd_acc_pend = 1'b0;
    rst_pend    = 1'b1;
    exp_cnt     = 0;
    checking    = 1'b1;
  endtask

  // Monitor: compare outputs shortly after each active edge.
  always @(posedge baud_clk) begin
    #1;
    if (checking) begin
      if (rst_pend) begin
        exp_rd = 8'h00;
      end else if (rd_acc_pend) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL scoreboard: read with no expected byte at %0t", $time);
        end else begin
          exp_rd = exp_q.pop_front();
        end
      end
      chk("rd_data", 32'(rd_data), 32'(exp_rd));
      chk("count", 32'(count), 32'(exp_cnt));
      chk("full", 32'(full), 32'(exp_cnt == DEPTH));
      chk("empty", 32'(empty), 32'(exp_cnt == 0));
      chk("almost_full", 32'(almost_full), 32'(exp_cnt >= AF_LEVEL));
`ifdef UART_TX_FIFO_ERR_EN
      chk("overflow", 32'(overflow), 32'(exp_ovf));
      chk("underflow", 32'(underflow), 32'(exp_udf));
`endif
    end
  end

  initial begin
    // Basic two-byte transfer.
    do_reset(1'b0, 1'b0);
    step(1'b1, 8'hA5, 1'b0);
    step(1'b1, 8'h3C, 1'b0);
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0);

    // Fill to full, overflow write dropped, drain in order.
    for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0);
    step(1'b1, 8'hFF, 1'b0);
    for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0);

    // Full with simultaneous read and write: read wins, write rejected.
    for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0);
    step(1'b1, 8'hEE, 1'b1);
    for (int i = 0; i < 15; i++) step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0);

    // Empty with simultaneous read and write: write wins, rd_data holds.
    step(1'b1, 8'h77, 1'b1);
    step(1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0);

    // Pointer wrap: three rounds of 10 writes then 10 reads.
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 10; i++) step(1'b1, 8'(8'h40 + k * 10 + i), 1'b0);
      for (int i = 0; i < 10; i++) step(1'b0, 8'h00, 1'b1);
    end
    // Steady streaming with concurrent read/write at a mid level.
    for (int i = 0; i < 4; i++) step(1'b1, 8'(8'hC0 + i), 1'b0);
    for (int i = 0; i < 8; i++) step(1'b1, 8'(8'hD0 + i), 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1);

`ifdef UART_TX_FIFO_ERR_EN
    // Sticky overflow, clear, set-beats-clear, then reset at count 5.
    for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0);
    step(1'b1, 8'hFF, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b1, 8'hFF, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1);
`endif

    // Reset mid-operation with competing requests.
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h90 + i), 1'b0);
    do_reset(1'b1, 1'b1);
    step(1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b1);
    step(1'b1, 8'h5A, 1'b0);
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0);

    @(negedge baud_clk);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard: %0d expected bytes never read, required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
